// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg: FSM state type and default counter width shared by clk_div_monitor
package clk_div_mon_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_e;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-FF synchronizer plus previous-value flop producing rise/fall strobes
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  // two metastability stages followed by a history stage for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) sh_q <= '0;
    else sh_q <= {sh_q[1:0], d_i};
  assign s_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock's period/high time and tracks lock to EXP_DIV; define CLK_DIV_MON_DUTY_CHECK_EN to also match duty
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXP_DIV  = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_clk_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] MAXM1 = MAX - 1'b1;
  localparam logic [CNT_W:0] EXP_W = (CNT_W+1)'(EXP_DIV);
  localparam logic [CNT_W:0] HALF_W = (CNT_W+1)'(EXP_DIV / 2);
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0] LOCK_W = MW'(LOCK_CNT);
  state_e st_q, st_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
  logic [MW-1:0] mcnt_q, mcnt_d, mcnt_inc;
  logic locked_q, locked_d, err_q, err_d, pv_q, pv_d, to_q, to_d, err_set;
  logic s, rise, fall, active, to_hit, duty_ok, match;
  logic [CNT_W:0] pm, pd;
  edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (div_clk_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );
  assign active = enable && st_q != IDLE;
  assign to_hit = pcnt_q == MAXM1 && !rise;
  assign pm = {1'b0, pcnt_q} + 1'b1;
  assign pd = pm > EXP_W ? pm - EXP_W : EXP_W - pm;
  assign match = pd <= TOL_W && duty_ok;
  assign mcnt_inc = mcnt_q + 1'b1;
  assign pcnt_d = (!active || rise) ? '0 : (pcnt_q == MAX) ? MAX : pcnt_q + 1'b1;
  assign err_d = err_set | (err_q & ~err_clr);
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt_q, ht_q;
  logic [CNT_W:0] hd;
  // high-phase counter restarts on each rise; completed high phases are captured on fall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt_q <= '0;
      ht_q <= '0;
    end else begin
      hcnt_q <= rise ? '0 : (s && hcnt_q != MAX) ? hcnt_q + 1'b1 : hcnt_q;
      if (active && fall) ht_q <= hcnt_q + 1'b1;
    end
  assign hd = {1'b0, ht_q} > HALF_W ? {1'b0, ht_q} - HALF_W : HALF_W - {1'b0, ht_q};
  assign duty_ok = hd <= TOL_W;
  assign high_time = ht_q;
`else
  logic unused_sync;
  assign unused_sync = &{1'b0, s, fall};
  assign duty_ok = 1'b1;
  assign high_time = '0;
`endif
  // lock tracker: acquire discards the partial first period, measure counts matches, lock watches for slips
  always_comb begin
    st_d = st_q;
    mcnt_d = mcnt_q;
    locked_d = locked_q;
    period_d = period_q;
    pv_d = 1'b0;
    to_d = 1'b0;
    err_set = 1'b0;
    if (!enable) begin
      st_d = IDLE;
      locked_d = 1'b0;
    end else if (st_q == IDLE) begin
      st_d = ACQ;
    end else if (to_hit) begin
      st_d = ACQ;
      locked_d = 1'b0;
      to_d = 1'b1;
      err_set = st_q == LOCK;
    end else if (rise) begin
      if (st_q == ACQ) begin
        st_d = MEAS;
        mcnt_d = '0;
      end else begin
        pv_d = 1'b1;
        period_d = pm[CNT_W-1:0];
        if (!match) begin
          mcnt_d = '0;
          if (st_q == LOCK) begin
            err_set = 1'b1;
            locked_d = 1'b0;
            st_d = MEAS;
          end
        end else if (st_q == MEAS) begin
          mcnt_d = mcnt_inc;
          if (mcnt_inc == LOCK_W) begin
            st_d = LOCK;
            locked_d = 1'b1;
          end
        end
      end
    end
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      pcnt_q <= '0;
      period_q <= '0;
      mcnt_q <= '0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      pv_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pcnt_q <= pcnt_d;
      period_q <= period_d;
      mcnt_q <= mcnt_d;
      locked_q <= locked_d;
      err_q <= err_d;
      pv_q <= pv_d;
      to_q <= to_d;
    end
  assign period = period_q;
  assign period_valid = pv_q;
  assign locked = locked_q;
  assign err = err_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed-vector scoreboard bench for clk_div_monitor (CNT_W=8, EXP_DIV=4, TOL=0, LOCK_CNT=4)
module tb_clk_div_monitor;
  localparam int CW = 8;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, div_clk_in = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] period, high_time;
  logic period_valid, locked, err, timeout;
  typedef struct { int p; int h; bit lk; bit er; int c; } exp_t;
  exp_t q[$];
  int to_q[$];
  exp_t e;
  int g;
  int checks = 0, errors = 0, cyc = 0, last_pv = 0;

  clk_div_monitor #(.CNT_W(CW), .EXP_DIV(4), .TOL(0), .LOCK_CNT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .div_clk_in   (div_clk_in),
    .err_clr      (err_clr),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int hx(input int h);
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    return h;
`else
    return 0 * h;
`endif
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a period or a timeout
  always @(negedge clk) begin
    if (!reset && period_valid) begin
      last_pv = cyc;
      chk("pv_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pv_latency", cyc - e.c, 3);
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("locked", locked, e.lk);
        chk("err", err, e.er);
      end
    end
    if (!reset && timeout) begin
      chk("timeout_expected", int'(to_q.size() > 0), 1);
      if (to_q.size() > 0) begin
        g = to_q.pop_front();
        chk("timeout_gap", cyc - last_pv, g);
        chk("timeout_locked", locked, 0);
        chk("timeout_err", err, 1);
      end
    end
  end

  // one divided-clock period starting with a rise; that rise ends the previous period (p,h)
  task automatic step(input int len, input int hi, input bit v, input int p, input int h,
                      input bit lk, input bit er, input int clr_at);
    if (v) q.push_back('{p, hx(h), lk, er, cyc});
    for (int i = 0; i < len; i++) begin
      div_clk_in = i < hi;
      err_clr = i == clr_at;
      @(negedge clk);
    end
    err_clr = 1'b0;
  endtask

  task automatic acquire_lock(input bit er);
    step(4, 2, 0, 0, 0, 0, 0, -1);
    for (int i = 1; i <= 4; i++) step(4, 2, 1, 4, 2, i == 4, er, -1);
  endtask

  task automatic do_reset();
    div_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("pv_queue_drained", q.size(), 0);
    chk("timeout_queue_drained", to_q.size(), 0);
    reset = 1'b1;
    q.delete();
    to_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    // /4 input locks on the 4th measured period
    acquire_lock(0);
    step(4, 2, 1, 4, 2, 1, 0, -1);
    step(4, 2, 1, 4, 2, 1, 0, -1);
    // /2 input never matches
    do_reset();
    step(2, 1, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 5; i++) step(2, 1, 1, 2, 1, 0, 0, -1);
    // lock, slip to /2, relock on /4, then clear err
    do_reset();
    acquire_lock(0);
    step(2, 1, 1, 4, 2, 1, 0, -1);
    step(2, 1, 1, 2, 1, 0, 1, -1);
    step(4, 2, 1, 2, 1, 0, 1, -1);
    for (int i = 1; i <= 4; i++) step(4, 2, 1, 4, 2, i == 4, 1, i == 4 ? 3 : -1);
    step(4, 2, 1, 4, 2, 1, 0, -1);
    // stuck-low input while locked
    do_reset();
    acquire_lock(0);
    step(4, 2, 1, 4, 2, 1, 0, -1);
    to_q.push_back(255);
    div_clk_in = 1'b0;
    repeat (270) @(negedge clk);
    acquire_lock(1);
    // err_clr in the same cycle as a lock slip: set wins
    do_reset();
    acquire_lock(0);
    step(6, 3, 1, 4, 2, 1, 0, -1);
    step(4, 2, 1, 6, 3, 0, 1, 2);
    for (int i = 1; i <= 4; i++) step(4, 2, 1, 4, 2, i == 4, 1, -1);
    step(4, 2, 1, 4, 2, 1, 1, -1);
    // asynchronous reset mid-lock
    @(negedge clk);
    chk("pre_rst_locked", locked, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_period", period, 0);
    chk("async_rst_high_time", high_time, 0);
    chk("async_rst_pv", period_valid, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_timeout", timeout, 0);
    q.delete();
    to_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    acquire_lock(0);
    step(4, 2, 1, 4, 2, 1, 0, -1);
    div_clk_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("final_pv_queue", q.size(), 0);
    chk("final_timeout_queue", to_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
